// File: rtl/multdiv_fast_unit_if.sv
// Handshake bundle between the ID stage (master) and the multiply/divide unit (slave).
interface multdiv_fast_unit_if;
  logic        mult_en_i;
  logic        div_en_i;
  logic        mult_sel_i;
  logic        div_sel_i;
  logic [1:0]  operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        data_ind_timing_i;
  logic        multdiv_ready_id_i;
  logic [31:0] multdiv_result_o;
  logic        valid_o;

  modport master (
    output mult_en_i, div_en_i, mult_sel_i, div_sel_i, operator_i, signed_mode_i,
           op_a_i, op_b_i, data_ind_timing_i, multdiv_ready_id_i,
    input  multdiv_result_o, valid_o
  );

  modport slave (
    input  mult_en_i, div_en_i, mult_sel_i, div_sel_i, operator_i, signed_mode_i,
           op_a_i, op_b_i, data_ind_timing_i, multdiv_ready_id_i,
    output multdiv_result_o, valid_o
  );
endinterface

// File: rtl/multdiv_fast_unit.sv
// RV32M multiply/divide unit: 33x33 signed multiplier plus radix-2 restoring divider.
// The divider and its FSM exist only when MULTDIV_DIV_EN is defined.
module multdiv_fast_unit #(
  parameter int unsigned RV32M = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multdiv_fast_unit_if.slave bus
);

  logic [32:0] mul_a_ext;
  logic [32:0] mul_b_ext;
  logic [63:0] product;
  logic [31:0] mult_result_comb;
  logic [31:0] mult_result;
  logic        mult_valid;
  logic [31:0] div_result;
  logic        div_valid;

  always_comb begin
    mul_a_ext        = {bus.signed_mode_i[0] & bus.op_a_i[31], bus.op_a_i};
    mul_b_ext        = {bus.signed_mode_i[1] & bus.op_b_i[31], bus.op_b_i};
    product          = $signed(mul_a_ext) * $signed(mul_b_ext);
    mult_result_comb = bus.operator_i[0] ? product[63:32] : product[31:0];
  end

  generate
    if (RV32M == 2) begin : g_mult_reg
      logic [31:0] mult_result_q;
      logic        mult_valid_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          mult_result_q <= '0;
          mult_valid_q  <= 1'b0;
        end else if (!bus.mult_en_i) begin
          mult_valid_q  <= 1'b0;
        end else if (mult_valid_q) begin
          if (bus.multdiv_ready_id_i) mult_valid_q <= 1'b0;
        end else begin
          mult_result_q <= mult_result_comb;
          mult_valid_q  <= 1'b1;
        end
      end

      assign mult_result = mult_result_q;
      assign mult_valid  = mult_valid_q;
    end else begin : g_mult_comb
      assign mult_result = mult_result_comb;
      assign mult_valid  = bus.mult_en_i;
    end
  endgenerate

`ifdef MULTDIV_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_ABS, S_LONG, S_FIX, S_DONE} div_state_e;

  div_state_e  state_q;
  logic [31:0] op_a_q, op_b_q;
  logic [1:0]  sm_q;
  logic        rem_sel_q, dit_q;
  logic [31:0] rem_q, quo_q, divisor_q;
  logic [4:0]  cnt_q;
  logic        quo_neg_q, rem_neg_q, div_zero_q;
  logic [31:0] div_result_q;
  logic        div_valid_q;

  logic        div_go;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [31:0] step_rem_in, step_quo_in, step_dvs;
  logic [31:0] step_rem, step_quo;
  logic [31:0] fix_result;

  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] shifted;
    logic [32:0] diff;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    if (diff[32]) return {shifted[31:0], quo[30:0], 1'b0};
    else          return {diff[31:0], quo[30:0], 1'b1};
  endfunction

  assign div_go = bus.div_en_i & ~bus.mult_en_i;

  // ABS also performs the first restoring step, so LONG covers the remaining 31
  // and the full divide still lands in DONE 34 cycles after the enable cycle.
  always_comb begin
    a_neg       = sm_q[0] & op_a_q[31];
    b_neg       = sm_q[1] & op_b_q[31];
    abs_a       = a_neg ? -op_a_q : op_a_q;
    abs_b       = b_neg ? -op_b_q : op_b_q;
    step_rem_in = (state_q == S_ABS) ? '0    : rem_q;
    step_quo_in = (state_q == S_ABS) ? abs_a : quo_q;
    step_dvs    = (state_q == S_ABS) ? abs_b : divisor_q;
    {step_rem, step_quo} = div_step(step_rem_in, step_quo_in, step_dvs);
    if (div_zero_q)     fix_result = rem_sel_q ? op_a_q : '1;
    else if (rem_sel_q) fix_result = rem_neg_q ? -rem_q : rem_q;
    else                fix_result = quo_neg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sm_q         <= '0;
      rem_sel_q    <= 1'b0;
      dit_q        <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      divisor_q    <= '0;
      cnt_q        <= '0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      div_result_q <= '0;
      div_valid_q  <= 1'b0;
    end else if (state_q != S_IDLE && !div_go) begin
      state_q     <= S_IDLE;
      div_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_go) begin
            op_a_q    <= bus.op_a_i;
            op_b_q    <= bus.op_b_i;
            sm_q      <= bus.signed_mode_i;
            rem_sel_q <= bus.operator_i[0];
            dit_q     <= bus.data_ind_timing_i;
            state_q   <= S_ABS;
          end
        end
        S_ABS: begin
          quo_neg_q  <= a_neg ^ b_neg;
          rem_neg_q  <= a_neg;
          divisor_q  <= abs_b;
          div_zero_q <= (op_b_q == '0);
          rem_q      <= step_rem;
          quo_q      <= step_quo;
          cnt_q      <= 5'd30;
          if (op_b_q == '0 && !dit_q) begin
            div_result_q <= rem_sel_q ? op_a_q : '1;
            div_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            state_q      <= S_LONG;
          end
        end
        S_LONG: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          div_result_q <= fix_result;
          div_valid_q  <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (bus.multdiv_ready_id_i) begin
            div_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_result = div_result_q;
  assign div_valid  = div_valid_q & div_go;
`else
  logic unused_div_inputs;
  assign unused_div_inputs = ^{clk_i, bus.operator_i[1], bus.data_ind_timing_i};
  assign div_result        = '0;
  assign div_valid         = bus.div_en_i;
`endif

  assign bus.valid_o          = ~rst_i & (bus.mult_en_i ? mult_valid : div_valid);
  assign bus.multdiv_result_o = bus.mult_sel_i ? mult_result :
                                bus.div_sel_i  ? div_result  : '0;

endmodule

// File: tb/tb_multdiv_fast_unit.sv
// Bench for multdiv_fast_unit: spec vector table, multi-cycle corner sequences and
// randomized operations against an arithmetic reference model (RV32M=1 and RV32M=2 instances).
module tb_multdiv_fast_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multdiv_fast_unit_if bus1();
  multdiv_fast_unit_if bus2();

  multdiv_fast_unit #(.RV32M(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  multdiv_fast_unit #(.RV32M(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  assign bus2.mult_en_i          = bus1.mult_en_i;
  assign bus2.div_en_i           = bus1.div_en_i;
  assign bus2.mult_sel_i         = bus1.mult_sel_i;
  assign bus2.div_sel_i          = bus1.div_sel_i;
  assign bus2.operator_i         = bus1.operator_i;
  assign bus2.signed_mode_i      = bus1.signed_mode_i;
  assign bus2.op_a_i             = bus1.op_a_i;
  assign bus2.op_b_i             = bus1.op_b_i;
  assign bus2.data_ind_timing_i  = bus1.data_ind_timing_i;
  assign bus2.multdiv_ready_id_i = bus1.multdiv_ready_id_i;

  typedef struct {
    string       name;
    bit          is_div;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    bit          dit;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain 64-bit arithmetic on the extended operand values.
  function automatic logic [31:0] ref_result(input bit is_div, input logic [1:0] op,
                                             input logic [1:0] sm, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      av, bv, q, r;
    logic [63:0] p;
    av = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    bv = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      p = av * bv;
      return op[0] ? p[63:32] : p[31:0];
    end
`ifdef MULTDIV_DIV_EN
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    q = av / bv;
    r = av % bv;
    return op[0] ? r[31:0] : q[31:0];
`else
    q = 0;
    r = 0;
    return 32'd0;
`endif
  endfunction

  function automatic int ref_latency(input bit is_div, input logic [31:0] b, input bit dit);
`ifdef MULTDIV_DIV_EN
    if (!is_div) return 0;
    return (b == 32'd0 && !dit) ? 2 : 34;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input bit is_div, input logic [1:0] op,
                         input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                         input bit dit, input logic [31:0] exp_res, input int exp_lat);
    vec_t v;
    v.name = name; v.is_div = is_div; v.op = op; v.sm = sm; v.a = a; v.b = b;
    v.dit = dit; v.exp_res = exp_res; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  task automatic idle();
    bus1.mult_en_i = 1'b0; bus1.div_en_i = 1'b0; bus1.mult_sel_i = 1'b0; bus1.div_sel_i = 1'b0;
    bus1.operator_i = 2'd0; bus1.signed_mode_i = 2'd0; bus1.op_a_i = '0; bus1.op_b_i = '0;
    bus1.data_ind_timing_i = 1'b0; bus1.multdiv_ready_id_i = 1'b1;
  endtask

  task automatic drive(input bit is_div, input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b, input bit dit);
    bus1.mult_en_i = !is_div; bus1.div_en_i = is_div;
    bus1.mult_sel_i = !is_div; bus1.div_sel_i = is_div;
    bus1.operator_i = op; bus1.signed_mode_i = sm; bus1.op_a_i = a; bus1.op_b_i = b;
    bus1.data_ind_timing_i = dit;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    #1;
    while (bus1.valid_o !== 1'b1 && lat < 60) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit is_div, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b, input bit dit,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    drive(is_div, op, sm, a, b, dit);
    wait_valid(lat);
    res = bus1.multdiv_result_o;
    @(negedge clk);
    idle();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, exp_r, ra, rb;
    logic [1:0]  rop, rsm;
    bit          rdiv, rdit;
    int          lat;

    add_vec("mull_7x-3",     0, 2'd0, 2'b10, 32'd7,        32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 0);
    add_vec("mulh_ss",       0, 2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0);
    add_vec("mulhu",         0, 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 0);
    add_vec("mulhsu",        0, 2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
`ifdef MULTDIV_DIV_EN
    add_vec("div_-7_2",      1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2,        0, 32'hFFFF_FFFD, 34);
    add_vec("rem_-7_2",      1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2,        0, 32'hFFFF_FFFF, 34);
    add_vec("divu_5_0_fast", 1, 2'd2, 2'b00, 32'd5,        32'd0,        0, 32'hFFFF_FFFF, 2);
    add_vec("remu_5_0_fast", 1, 2'd3, 2'b00, 32'd5,        32'd0,        0, 32'd5,        2);
    add_vec("divu_5_0_dit",  1, 2'd2, 2'b00, 32'd5,        32'd0,        1, 32'hFFFF_FFFF, 34);
    add_vec("div_neg_0_dit", 1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd0,        1, 32'hFFFF_FFFF, 34);
    add_vec("rem_neg_0_dit", 1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd0,        1, 32'hFFFF_FFF9, 34);
    add_vec("div_ovf",       1, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 34);
    add_vec("rem_ovf",       1, 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0,        34);
    add_vec("divu_100_7",    1, 2'd2, 2'b00, 32'd100,      32'd7,        0, 32'd14,       34);
`else
    add_vec("div_off",       1, 2'd2, 2'b00, 32'd100,      32'd7,        0, 32'd0,        0);
    add_vec("rem_off",       1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2,        0, 32'd0,        0);
`endif

    idle();
    rst = 1'b1;
    bus1.mult_en_i = 1'b1; bus1.mult_sel_i = 1'b1; bus1.op_a_i = 32'd3; bus1.op_b_i = 32'd4;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_m1", 32'(bus1.valid_o), 32'd0);
    check("rst_valid_m2", 32'(bus2.valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus1.mult_en_i = 1'b1; bus1.op_a_i = 32'd3; bus1.op_b_i = 32'd4;
    #1;
    check("nosel_result", bus1.multdiv_result_o, 32'd0);
    check("nosel_valid", 32'(bus1.valid_o), 32'd1);
    @(negedge clk);
    idle();

    foreach (vecs[i]) begin
      run_op(vecs[i].is_div, vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].dit, res, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Registered multiplier: valid one cycle late, product latched at start.
    @(negedge clk);
    drive(0, 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    #1;
    check("m2_valid_early", 32'(bus2.valid_o), 32'd0);
    @(negedge clk);
    bus1.op_a_i = 32'd0;
    #1;
    check("m2_valid", 32'(bus2.valid_o), 32'd1);
    check("m2_result", bus2.multdiv_result_o, 32'hFFFF_FFFE);
    @(negedge clk);
    idle();

    // Both enables: multiply wins; divide only starts once mult_en drops.
    @(negedge clk);
    drive(0, 2'd0, 2'b00, 32'd42, 32'd7, 0);
    bus1.div_en_i = 1'b1;
    repeat (3) begin
      #1;
      check("both_valid", 32'(bus1.valid_o), 32'd1);
      check("both_result", bus1.multdiv_result_o, 32'd294);
      @(negedge clk);
    end
    drive(1, 2'd2, 2'b00, 32'd42, 32'd7, 0);
    wait_valid(lat);
    check("after_both_res", bus1.multdiv_result_o, ref_result(1, 2'd2, 2'b00, 32'd42, 32'd7));
    check("after_both_lat", 32'(lat), 32'(ref_latency(1, 32'd7, 0)));
    @(negedge clk);
    idle();

`ifdef MULTDIV_DIV_EN
    // Result held in DONE until ready.
    @(negedge clk);
    drive(1, 2'd2, 2'b00, 32'd100, 32'd7, 0);
    bus1.multdiv_ready_id_i = 1'b0;
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd34);
    repeat (3) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(bus1.valid_o), 32'd1);
      check("hold_result", bus1.multdiv_result_o, 32'd14);
    end
    bus1.multdiv_ready_id_i = 1'b1;
    @(negedge clk); #1;
    check("retire_valid", 32'(bus1.valid_o), 32'd0);
    idle();

    // Enable dropped mid-divide aborts; next op runs full latency.
    @(negedge clk);
    drive(1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    repeat (5) @(negedge clk);
    idle();
    #1;
    check("abort_valid", 32'(bus1.valid_o), 32'd0);
    run_op(1, 2'd2, 2'b00, 32'd100, 32'd7, 0, res, lat);
    check("abort_next_res", res, 32'd14);
    check("abort_next_lat", 32'(lat), 32'd34);

    // Reset at LONG step 10, then the held request restarts cleanly.
    @(negedge clk);
    drive(1, 2'd2, 2'b00, 32'd100, 32'd7, 0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus1.valid_o), 32'd0);
    wait_valid(lat);
    check("rst_mid_res", bus1.multdiv_result_o, 32'd14);
    check("rst_mid_lat", 32'(lat), 32'd34);
    @(negedge clk);
    idle();

    // Operand changes after start are ignored.
    @(negedge clk);
    drive(1, 2'd2, 2'b00, 32'd100, 32'd7, 0);
    repeat (3) @(negedge clk);
    bus1.op_a_i = 32'd999; bus1.op_b_i = 32'd3; bus1.operator_i = 2'd3; bus1.signed_mode_i = 2'b11;
    wait_valid(lat);
    check("latch_res", bus1.multdiv_result_o, 32'd14);
    check("latch_lat", 32'(lat + 3), 32'd34);
    @(negedge clk);
    idle();
`endif

    for (int n = 0; n < 40; n++) begin
      rdiv = 1'($urandom_range(0, 1));
      rop  = {rdiv, 1'($urandom_range(0, 1))};
      rsm  = 2'($urandom_range(0, 3));
      rdit = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rsm = 2'b11;
      end
      exp_r = ref_result(rdiv, rop, rsm, ra, rb);
      run_op(rdiv, rop, rsm, ra, rb, rdit, res, lat);
      check($sformatf("rand%0d_res op=%0d sm=%0d a=%08h b=%08h", n, rop, rsm, ra, rb), res, exp_r);
      check($sformatf("rand%0d_lat", n), 32'(lat), 32'(ref_latency(rdiv, rb, rdit)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
